digit_sprite_blitter: RTL and testbench
=======================================

DIGIT_SPRITE_BLITTER -- requirements
Module: digit_sprite_blitter

Interface
REQ-001 SHALL have parameter WIDTH, default 36, glyph width in source pixels.
REQ-002 SHALL have parameter HEIGHT, default 96, glyph height in source pixels.
REQ-003 SHALL have parameter NUM_GLYPHS, default 10, glyphs stored back-to-back in glyph ROM.
REQ-004 SHALL have parameter ADDR_W, default 16, glyph ROM address width.
REQ-005 SHALL have parameter TRANSPARENT_IDX, default 0, colour index rendered as transparent.
REQ-006 SHALL have parameter BLINK_FRAMES, default 30, frames per blink half-period.
REQ-007 SHALL have one clock and an asynchronous, active-high reset; ports pixel_clk and reset.
REQ-008 pixel_clk  input  1  pixel clock; all state on rising edge.
REQ-009 reset  input  1  asynchronous active-high reset.
REQ-010 x, hcount  input  11 each  sprite left edge; current scan column.
REQ-011 y, vcount  input  10 each  sprite top edge; current scan row.
REQ-012 digit  input  4  glyph select.
REQ-013 scale  input  1  0 = 1x, 1 = 2x pixel replication.
REQ-014 blink_en  input  1  enable blinking.
REQ-015 rom_addr  output  ADDR_W  registered glyph ROM address.
REQ-016 rom_data  input  8  glyph ROM colour index, valid the cycle after rom_addr is driven.
REQ-017 pal_addr  output  8  registered palette address.
REQ-018 pal_data  input  24  palette {R,G,B}, valid the cycle after pal_addr is driven.
REQ-019 pixel  output  24  registered {R,G,B}; 0 when not drawn.
REQ-020 pixel_on  output  1  registered; 1 when pixel is an opaque sprite pixel.

Function
REQ-021 Frame start SHALL be the cycle with hcount==0 and vcount==0.
REQ-022 digit SHALL be latched into digit_lat only at frame start; mid-frame changes SHALL NOT affect the current frame.
REQ-023 Box SHALL be hcount in [x, x+(WIDTH<<scale)) and vcount in [y, y+(HEIGHT<<scale)), compared at 12/11-bit width so right/bottom edges past 2047/1023 do not wrap.
REQ-024 In box: col=(hcount-x)>>scale, row=(vcount-y)>>scale, rom_addr=digit_lat*WIDTH*HEIGHT+row*WIDTH+col, truncated to ADDR_W; out of box rom_addr SHALL be 0.
REQ-025 Stage 1 (edge N): register rom_addr and a draw flag = in-box AND digit_lat<NUM_GLYPHS AND visible.
REQ-026 Stage 2 (edge N+2): register pal_addr=rom_data, plus opaque flag = draw AND rom_data!=TRANSPARENT_IDX.
REQ-027 Stage 3 (edge N+4): pixel=pal_data and pixel_on=1 if opaque, else pixel=0 and pixel_on=0.
REQ-028 Total latency SHALL be fixed at 4 pixel_clk cycles from hcount/vcount sample to pixel; flags SHALL be delayed to stay aligned.
REQ-029 Pipeline SHALL accept a new coordinate every cycle with no stalls.
REQ-030 digit_lat>=NUM_GLYPHS SHALL blank the whole sprite (pixel_on=0).
REQ-031 Blink: frame counter counts frame starts 0..BLINK_FRAMES-1, wraps to 0 and toggles phase at wrap.
REQ-032 visible = 1 when blink_en=0, else phase==0; counter runs regardless of blink_en.
REQ-033 scale changes SHALL take effect immediately (not frame-latched).

Reset
REQ-034 On reset: rom_addr=0, pal_addr=0, pixel=0, pixel_on=0, all pipeline flags 0, digit_lat=0, blink counter=0, phase=0 (visible).
REQ-035 Reset asserted mid-frame SHALL clear the pipeline within the same cycle; first valid pixel SHALL be 4 cycles after the first sample following reset release.

Verification
REQ-036 x=100,y=50,digit=3 latched,scale=0,hcount=101,vcount=52 -> rom_addr=3*3456+2*36+1=10441 one cycle later; pixel=pal_data 4 cycles after sample.
REQ-037 scale=1,x=0,y=0,hcount=71,vcount=191 -> in box, col=35,row=95, rom_addr=3455 for digit 0; hcount=72 -> pixel_on=0.
REQ-038 rom_data=TRANSPARENT_IDX in box -> pixel=0,pixel_on=0; rom_data=5 -> pal_addr=5, pixel=pal_data.
REQ-039 digit 2->7 mid-frame -> rest of frame renders glyph 2; next frame glyph 7; digit=12 -> sprite blank.
REQ-040 blink_en=1 -> sprite visible 30 frames, blank 30 frames, repeat; reset mid-frame -> pixel=0 immediately, phase visible, counter 0.
REQ-041 x=2040,hcount=2047,scale=0 -> in box (no wrap); hcount=5 -> out of box.

Source files
------------

// File: rtl/digit_sprite_blitter.sv
// digit_sprite_blitter: draws one glyph from a glyph ROM as a sprite at (x, y),
// with optional 2x pixel replication and frame-based blinking.
// Fixed 4-cycle latency from hcount/vcount sample to pixel; one sample per cycle.
//
// Ports:
//   pixel_clk, reset     clock, asynchronous active-high reset
//   x, hcount            sprite left edge, current scan column (11 bit)
//   y, vcount            sprite top edge, current scan row (10 bit)
//   digit                glyph select, latched at frame start
//   scale                0 = 1x, 1 = 2x replication (takes effect immediately)
//   blink_en             enable blinking
//   rom_addr / rom_data  glyph ROM address (registered) / colour index (1 cycle later)
//   pal_addr / pal_data  palette address (registered) / {R,G,B} (1 cycle later)
//   pixel, pixel_on      registered {R,G,B} and opaque flag; 0 when not drawn
module digit_sprite_blitter #(
  parameter int unsigned WIDTH           = 36,
  parameter int unsigned HEIGHT          = 96,
  parameter int unsigned NUM_GLYPHS      = 10,
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned TRANSPARENT_IDX = 0,
  parameter int unsigned BLINK_FRAMES    = 30
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic [10:0]       x,
  input  logic [10:0]       hcount,
  input  logic [9:0]        y,
  input  logic [9:0]        vcount,
  input  logic [3:0]        digit,
  input  logic              scale,
  input  logic              blink_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        pal_addr,
  input  logic [23:0]       pal_data,
  output logic [23:0]       pixel,
  output logic              pixel_on
);

  localparam int unsigned GLYPH_PIX = WIDTH * HEIGHT;
  localparam int unsigned BLINK_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Frame-latched state
  logic [3:0]         digit_lat;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  // Pipeline flags
  logic draw_s1;
  logic draw_s2;
  logic opaque_s2;
  logic opaque_s3;

  // Combinational geometry
  logic              frame_start_c;
  logic [11:0]       h_ext_c, x_ext_c, w_span_c, dx_c;
  logic [10:0]       v_ext_c, y_ext_c, h_span_c, dy_c;
  logic              in_box_c;
  logic [10:0]       col_c;
  logic [9:0]        row_c;
  logic              visible_c;
  logic              glyph_ok_c;
  logic [ADDR_W-1:0] addr_c;

  // Box test and glyph address; one extra bit so edges past the screen do not wrap
  always_comb begin
    frame_start_c = (hcount == 11'd0) && (vcount == 10'd0);
    h_ext_c       = {1'b0, hcount};
    x_ext_c       = {1'b0, x};
    w_span_c      = 12'(WIDTH) << scale;
    v_ext_c       = {1'b0, vcount};
    y_ext_c       = {1'b0, y};
    h_span_c      = 11'(HEIGHT) << scale;
    dx_c          = h_ext_c - x_ext_c;
    dy_c          = v_ext_c - y_ext_c;
    in_box_c      = (h_ext_c >= x_ext_c) && (h_ext_c < x_ext_c + w_span_c) &&
                    (v_ext_c >= y_ext_c) && (v_ext_c < y_ext_c + h_span_c);
    col_c         = 11'(dx_c >> scale);
    row_c         = 10'(dy_c >> scale);
    visible_c     = !blink_en || !blink_phase;
    glyph_ok_c    = 32'(digit_lat) < NUM_GLYPHS;
    addr_c        = '0;
    if (in_box_c) begin
      addr_c = ADDR_W'(32'(digit_lat) * GLYPH_PIX + 32'(row_c) * WIDTH + 32'(col_c));
    end
  end

  // Digit latch and blink counter, both advanced only at frame start
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      digit_lat   <= 4'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start_c) begin
      digit_lat <= digit;
      if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Three registered stages; flags carry across the ROM/palette read cycles
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      rom_addr  <= '0;
      draw_s1   <= 1'b0;
      draw_s2   <= 1'b0;
      pal_addr  <= 8'd0;
      opaque_s2 <= 1'b0;
      opaque_s3 <= 1'b0;
      pixel     <= 24'd0;
      pixel_on  <= 1'b0;
    end else begin
      rom_addr  <= addr_c;
      draw_s1   <= in_box_c && glyph_ok_c && visible_c;
      draw_s2   <= draw_s1;
      pal_addr  <= rom_data;
      opaque_s2 <= draw_s2 && (rom_data != 8'(TRANSPARENT_IDX));
      opaque_s3 <= opaque_s2;
      pixel     <= opaque_s3 ? pal_data : 24'd0;
      pixel_on  <= opaque_s3;
    end
  end

endmodule

// File: tb/tb_digit_sprite_blitter.sv
module tb_digit_sprite_blitter;

  localparam int W  = 36;
  localparam int H  = 96;
  localparam int NG = 10;
  localparam int BF = 30;

  logic        pixel_clk = 1'b0;
  logic        reset;
  logic [10:0] x, hcount;
  logic [9:0]  y, vcount;
  logic [3:0]  digit;
  logic        scale, blink_en;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data = 8'd0;
  logic [7:0]  pal_addr;
  logic [23:0] pal_data = 24'd0;
  logic [23:0] pixel;
  logic        pixel_on;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int digit_m, cnt_m, phase_m;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  pal;
    logic        on;
    logic [23:0] pix;
  } exp_t;
  exp_t hist[$];

  digit_sprite_blitter dut (
    .pixel_clk(pixel_clk), .reset(reset),
    .x(x), .hcount(hcount), .y(y), .vcount(vcount),
    .digit(digit), .scale(scale), .blink_en(blink_en),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pal_addr(pal_addr), .pal_data(pal_data),
    .pixel(pixel), .pixel_on(pixel_on)
  );

  always #5 pixel_clk = ~pixel_clk;

  function automatic logic [7:0] rom_fn(input int a);
    int t;
    t = a * 13 + (a >> 4);
    if (t % 5 == 0) return 8'd0;
    return 8'(t) | 8'h01;
  endfunction

  function automatic logic [23:0] pal_fn(input logic [7:0] p);
    return {p, ~p, p ^ 8'h5a};
  endfunction

  // Synchronous ROM and palette: data valid the cycle after the address
  always @(posedge pixel_clk) begin
    rom_data <= rom_fn(int'(rom_addr));
    pal_data <= pal_fn(pal_addr);
  end

  // One pixel clock: present (h, v), predict, then compare all pipeline outputs
  task automatic cycle(input int h, input int v);
    exp_t e;
    int hi, vi, xi, yi, wspan, hspan, col, row;
    bit inb, draw;
    hcount = 11'(h);
    vcount = 10'(v);
    hi = int'(hcount); vi = int'(vcount); xi = int'(x); yi = int'(y);
    wspan = W * (scale ? 2 : 1);
    hspan = H * (scale ? 2 : 1);
    inb = hi >= xi && hi < xi + wspan && vi >= yi && vi < yi + hspan;
    col = (hi - xi) / (scale ? 2 : 1);
    row = (vi - yi) / (scale ? 2 : 1);
    e.addr = inb ? 16'(digit_m * W * H + row * W + col) : 16'd0;
    draw = inb && digit_m < NG && (!blink_en || phase_m == 0);
    e.pal = rom_fn(int'(e.addr));
    e.on  = draw && e.pal != 8'd0;
    e.pix = e.on ? pal_fn(e.pal) : 24'd0;
    hist.push_back(e);
    if (hi == 0 && vi == 0) begin
      digit_m = int'(digit);
      cnt_m++;
      if (cnt_m == BF) begin
        cnt_m = 0;
        phase_m = 1 - phase_m;
      end
    end
    @(posedge pixel_clk); #1;
    checks++;
    if (rom_addr !== hist[hist.size()-1].addr) begin
      errors++;
      $display("FAIL rom_addr h=%0d v=%0d: got %0d expected %0d", hi, vi, rom_addr, hist[hist.size()-1].addr);
    end
    if (hist.size() >= 3) begin
      checks++;
      if (pal_addr !== hist[hist.size()-3].pal) begin
        errors++;
        $display("FAIL pal_addr: got %0d expected %0d", pal_addr, hist[hist.size()-3].pal);
      end
    end
    checks++;
    if (hist.size() >= 5) begin
      if (pixel !== hist[hist.size()-5].pix || pixel_on !== hist[hist.size()-5].on) begin
        errors++;
        $display("FAIL pixel: got %h/%b expected %h/%b", pixel, pixel_on,
                 hist[hist.size()-5].pix, hist[hist.size()-5].on);
      end
    end else if (pixel !== 24'd0 || pixel_on !== 1'b0) begin
      errors++;
      $display("FAIL pixel_warmup: got %h/%b expected 0/0", pixel, pixel_on);
    end
    if (hist.size() > 5) void'(hist.pop_front());
  endtask

  task automatic flush();
    repeat (5) cycle(2000, 1000);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge pixel_clk);
    #1 reset = 1'b0;
    digit_m = 0; cnt_m = 0; phase_m = 0;
    hist.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if (rom_addr !== 16'd0 || pal_addr !== 8'd0 || pixel !== 24'd0 || pixel_on !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %0d %0d %h %b expected 0 0 0 0", rom_addr, pal_addr, pixel, pixel_on);
    end
    apply_reset();
    // First samples after release: warm-up window must stay blank
    x = 11'd0; y = 10'd0;
    cycle(1, 1); cycle(2, 1); cycle(3, 1); cycle(4, 1); cycle(5, 1);
  endtask

  task automatic test_directed_address();
    x = 11'd100; y = 10'd50; digit = 4'd3; scale = 1'b0; blink_en = 1'b0;
    cycle(0, 0);
    cycle(101, 52);
    checks++;
    if (rom_addr !== 16'd10441) begin
      errors++;
      $display("FAIL addr_10441: got %0d expected 10441", rom_addr);
    end
    flush();
  endtask

  task automatic test_scale2_edge();
    x = 11'd0; y = 10'd0; digit = 4'd0; scale = 1'b1;
    cycle(0, 0);
    cycle(71, 191);
    checks++;
    if (rom_addr !== 16'd3455) begin
      errors++;
      $display("FAIL scale2_last: got %0d expected 3455", rom_addr);
    end
    cycle(72, 191);
    checks++;
    if (rom_addr !== 16'd0) begin
      errors++;
      $display("FAIL scale2_outside: got %0d expected 0", rom_addr);
    end
    flush();
    scale = 1'b0;
  endtask

  task automatic test_no_wrap();
    x = 11'd2040; y = 10'd0; digit = 4'd1; scale = 1'b0;
    cycle(0, 0);
    cycle(2047, 5);
    checks++;
    if (rom_addr !== 16'(3456 + 5 * 36 + 7))  begin
      errors++;
      $display("FAIL right_edge: got %0d expected %0d", rom_addr, 3456 + 5 * 36 + 7);
    end
    cycle(5, 5);
    checks++;
    if (rom_addr !== 16'd0) begin
      errors++;
      $display("FAIL no_wrap: got %0d expected 0", rom_addr);
    end
    flush();
  endtask

  task automatic test_digit_latch();
    x = 11'd10; y = 10'd10; scale = 1'b0;
    digit = 4'd2;
    cycle(0, 0);
    digit = 4'd7;
    cycle(20, 30);
    checks++;
    if (rom_addr !== 16'(2 * 3456 + 20 * 36 + 10)) begin
      errors++;
      $display("FAIL midframe_digit: got %0d expected %0d", rom_addr, 2 * 3456 + 20 * 36 + 10);
    end
    for (int i = 0; i < 8; i++) cycle(10 + i, 12 + i);
    cycle(0, 0);
    cycle(20, 30);
    checks++;
    if (rom_addr !== 16'(7 * 3456 + 20 * 36 + 10)) begin
      errors++;
      $display("FAIL nextframe_digit: got %0d expected %0d", rom_addr, 7 * 3456 + 20 * 36 + 10);
    end
    digit = 4'd12;
    cycle(0, 0);
    for (int i = 0; i < 10; i++) cycle(10 + i, 10 + 3 * i);
    flush();
    checks++;
    if (pixel_on !== 1'b0) begin
      errors++;
      $display("FAIL blank_glyph: got %b expected 0", pixel_on);
    end
  endtask

  task automatic test_blink();
    int vis_frames;
    apply_reset();
    x = 11'd1; y = 10'd1; digit = 4'd4; scale = 1'b0; blink_en = 1'b1;
    vis_frames = 0;
    for (int f = 0; f < 65; f++) begin
      cycle(0, 0);
      for (int i = 0; i < 8; i++) cycle(1 + i, 1);
      if (phase_m == 0) vis_frames++;
    end
    flush();
    checks++;
    if (vis_frames != 35) begin
      errors++;
      $display("FAIL blink_model_frames: got %0d expected 35", vis_frames);
    end
    blink_en = 1'b0;
  endtask

  task automatic test_midframe_reset();
    x = 11'd0; y = 10'd0; digit = 4'd5; blink_en = 1'b1;
    cycle(0, 0);
    for (int i = 0; i < 6; i++) cycle(i, 2);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (pixel !== 24'd0 || pixel_on !== 1'b0 || rom_addr !== 16'd0 || pal_addr !== 8'd0) begin
      errors++;
      $display("FAIL async_reset_clear: got %h/%b %0d %0d expected 0", pixel, pixel_on, rom_addr, pal_addr);
    end
    @(posedge pixel_clk);
    #1 reset = 1'b0;
    digit_m = 0; cnt_m = 0; phase_m = 0;
    hist.delete();
    for (int i = 0; i < 8; i++) cycle(i, 3);
    flush();
    blink_en = 1'b0;
  endtask

  task automatic test_random();
    int h, v;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        x = 11'($urandom_range(0, 2047));
        y = 10'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 9) == 0) scale = 1'($urandom);
      if ($urandom_range(0, 19) == 0) digit = 4'($urandom_range(0, 12));
      if ($urandom_range(0, 49) == 0) blink_en = 1'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        h = 0; v = 0;
      end else begin
        h = int'(x) + int'($urandom_range(0, 80)) - 4;
        v = int'(y) + int'($urandom_range(0, 200)) - 4;
      end
      cycle(h, v);
    end
    flush();
  endtask

  initial begin
    reset = 1'b1;
    x = 11'd0; y = 10'd0; hcount = 11'd0; vcount = 10'd0;
    digit = 4'd0; scale = 1'b0; blink_en = 1'b0;
    digit_m = 0; cnt_m = 0; phase_m = 0;
    test_reset();
    test_directed_address();
    test_scale2_edge();
    test_no_wrap();
    test_digit_latch();
    test_blink();
    test_midframe_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
